// File: rtl/wm8731_i2c_responder_if.sv
// wm8731_i2c_responder_if: I2C pad bundle (iic_sclk, iic_sdata_i from master; iic_sdata_oe open-drain pull-down from responder)
interface wm8731_i2c_responder_if;
  logic iic_sclk;
  logic iic_sdata_i;
  logic iic_sdata_oe;
  modport master (output iic_sclk, output iic_sdata_i, input iic_sdata_oe);
  modport slave (input iic_sclk, input iic_sdata_i, output iic_sdata_oe);
endinterface

// File: rtl/wm8731_i2c_responder.sv
// wm8731_i2c_responder: WM8731 I2C write responder; clk_50m/rst, iic pads, wr_valid/wr_addr/wr_data/wr_count commits, rd_addr->rd_data shadow read, sticky err_flag
module wm8731_i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int FILT_LEN = 3
) (
  input  logic clk_50m,
  input  logic rst,
  wm8731_i2c_responder_if.slave iic,
  output logic wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic [7:0] wr_count,
  output logic err_flag
);
  typedef enum logic [2:0] {IDLE, DEV, DEV_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE} state_t;
  localparam logic [8:0] DFLT [16] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
                                      9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
  logic [1:0] scl_s, sda_s;
  logic [FILT_LEN-1:0] scl_h, sda_h;
  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start, stop;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, rb;
  logic oe, oe_n, err_set, commit, shift;
  logic [8:0] regs [16];
  logic [6:0] c_addr;
  logic [8:0] c_data;
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start = scl_f & scl_p & sda_p & ~sda_f;
  assign stop = scl_f & scl_p & ~sda_p & sda_f;
  assign c_addr = rb[7:1];
  assign c_data = {rb[0], sh};
  assign rd_data = regs[rd_addr];
  assign iic.iic_sdata_oe = oe;
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_h <= '1;
      sda_h <= '1;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], iic.iic_sclk};
      sda_s <= {sda_s[0], iic.iic_sdata_i};
      scl_h <= {scl_h[FILT_LEN-2:0], scl_s[1]};
      sda_h <= {sda_h[FILT_LEN-2:0], sda_s[1]};
      scl_f <= &scl_h ? 1'b1 : ~|scl_h ? 1'b0 : scl_f;
      sda_f <= &sda_h ? 1'b1 : ~|sda_h ? 1'b0 : sda_f;
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  end
  always_ff @(posedge clk_50m) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    oe_n = oe;
    err_set = 1'b0;
    commit = 1'b0;
    shift = 1'b0;
    if (start) begin
      state_n = DEV;
      cnt_n = '0;
      err_set = (state inside {DEV, REG, DATA} && cnt != 4'd0) || state inside {REG_ACK, DATA, DATA_ACK};
    end else if (stop) begin
      state_n = IDLE;
      err_set = !(state inside {IDLE, IGNORE});
    end else if (state inside {DEV, REG, DATA}) begin
      shift = scl_rise;
      cnt_n = scl_rise ? cnt + 4'd1 : cnt;
      if (scl_fall && cnt == 4'd8) begin
        state_n = state_t'(state + 3'd1);
        oe_n = state != DEV || sh == {DEV_ADDR, 1'b0};
        err_set = state == DEV && sh != {DEV_ADDR, 1'b0};
      end
    end else if (state inside {DEV_ACK, REG_ACK, DATA_ACK}) begin
      if (scl_fall) begin
        oe_n = 1'b0;
        cnt_n = '0;
        commit = state == DATA_ACK;
        state_n = state == REG_ACK ? DATA : (state == DEV_ACK && sh == {DEV_ADDR, 1'b0}) ? REG : IGNORE;
      end
    end else if (state == IGNORE) begin
      cnt_n = scl_rise ? (cnt == 4'd8 ? 4'd0 : cnt + 4'd1) : cnt;
      err_set = scl_fall && cnt == 4'd8;
    end
  end
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      cnt <= '0;
      oe <= 1'b0;
      sh <= '0;
      rb <= '0;
      wr_valid <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_count <= '0;
      err_flag <= 1'b0;
    end else begin
      cnt <= cnt_n;
      oe <= oe_n;
      if (shift) sh <= {sh[6:0], sda_f};
      if (state == REG_ACK) rb <= sh;
      wr_valid <= commit;
      if (commit) begin
        wr_addr <= c_addr;
        wr_data <= c_data;
        wr_count <= wr_count + 8'd1;
      end
      err_flag <= err_flag | err_set | (commit && c_addr > 7'd9 && c_addr != 7'd15);
    end
  end
  always_ff @(posedge clk_50m) begin
    for (int i = 0; i < 16; i++)
      regs[i] <= (rst || (commit && c_addr == 7'd15)) ? DFLT[i] :
                 (commit && i < 10 && c_addr == 7'(i)) ? c_data : regs[i];
  end
endmodule
